// File: rtl/spi_servo_bridge.sv
// Purpose : SPI mode-0 slave that turns 24-bit frames {cmd[7:0], val[15:0]} into ServoController register writes.
// Latency : cs pulses 1 clk after the 24th synchronized sclk rise (SYNC_STAGES+2 clk from the pin edge).
// Backpressure: none; the host paces frames, and ss_n must stay high >= SYNC_STAGES+2 clk between frames.
//
// Ports: clk/rst_n (async active-low); sclk/mosi/ss_n SPI inputs (asynchronous to clk); miso SPI output;
//        cs/addr/data ServoController write port; frame_err one-cycle pulse on aborted or malformed frames.
// Optional: define SERVO_READBACK_EN to add four shadow registers readable through miso.
module spi_servo_bridge #(
  parameter int unsigned PULSE_MIN   = 500,
  parameter int unsigned PULSE_MAX   = 2500,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss_n,
  output logic        miso,
  output logic        cs,
  output logic [1:0]  addr,
  output logic [15:0] data,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [15:0] PMIN   = 16'(PULSE_MIN);
  localparam logic [15:0] PMAX   = 16'(PULSE_MAX);
  localparam logic [7:0]  SETTLE = 8'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic        sclk_dly_q, sclk_dly_d, ss_dly_q, ss_dly_d;
  logic [7:0]  settle_q, settle_d;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        cs_q, cs_d, err_q, err_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic sclk_s, mosi_s, ss_s, sclk_rise, ss_fall, ss_rise, settled, frame_done;

  function automatic logic [15:0] clamp(input logic [15:0] v);
    if (v < PMIN)      return PMIN;
    else if (v > PMAX) return PMAX;
    else               return v;
  endfunction

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign ss_rise   = ss_s & ~ss_dly_q;
  // Until the synchronizer chain and delay flop hold real pin samples, a low ss_n
  // at reset release would look like a falling edge; it must not start a frame.
  assign settled   = (settle_q == SETTLE);
  assign ss_fall   = ~ss_s & ss_dly_q & settled;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    sclk_dly_d  = sclk_s;
    ss_dly_d    = ss_s;
    settle_d    = settled ? settle_q : settle_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    cs_d       = 1'b0;
    err_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // The sclk edge is handled before a coincident ss_n rise, so a frame whose
        // last bit lands together with deselect still completes.
        if (sclk_rise) begin
          shift_d = {shift_q[22:0], mosi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            state_d    = DONE;
            frame_done = 1'b1;
          end
        end
        if (ss_rise) begin
          state_d = IDLE;
          if (!frame_done) err_d = 1'b1;
        end
      end
      DONE: begin
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (frame_done) begin
      if (shift_d[22:18] != 5'd0) begin
        err_d = 1'b1;
      end else if (shift_d[23]) begin
        cs_d   = 1'b1;
        addr_d = shift_d[17:16];
        data_d = clamp(shift_d[15:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b1;
      settle_q    <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      cs_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      ss_dly_q    <= ss_dly_d;
      settle_q    <= settle_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      cs_q        <= cs_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign cs        = cs_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign frame_err = err_q;

`ifdef SERVO_READBACK_EN
  logic [15:0] shadow_q [4];
  logic [15:0] shadow_d [4];
  logic [15:0] rd_sr_q, rd_sr_d;
  logic        miso_q, miso_d;
  logic        sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_dly_q;

  always_comb begin
    shadow_d = shadow_q;
    rd_sr_d  = rd_sr_q;
    miso_d   = miso_q;
    if (cs_d) shadow_d[addr_d] = data_d;
    // After 8 rises shift_q holds exactly the command byte; the falling edge that
    // follows loads the readback word (or zero for a non-read) and presents its MSB.
    if (state_q == SHIFT && sclk_fall) begin
      if (cnt_q == 5'd8) begin
        if (!shift_q[7] && shift_q[6:2] == 5'd0) begin
          miso_d  = shadow_q[shift_q[1:0]][15];
          rd_sr_d = {shadow_q[shift_q[1:0]][14:0], 1'b0};
        end else begin
          miso_d  = 1'b0;
          rd_sr_d = '0;
        end
      end else if (cnt_q > 5'd8) begin
        miso_d  = rd_sr_q[15];
        rd_sr_d = {rd_sr_q[14:0], 1'b0};
      end
    end
    if (state_d != SHIFT) miso_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
      rd_sr_q <= '0;
      miso_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      rd_sr_q  <= rd_sr_d;
      miso_q   <= miso_d;
    end
  end

  assign miso = miso_q;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_servo_bridge.sv
// Purpose : self-checking bench for spi_servo_bridge; directed frames plus randomized frames vs. a frame-level model.
// Latency : not applicable (bench).
// Backpressure: not applicable (bench).
module tb_spi_servo_bridge;

  localparam int unsigned PMIN = 500;
  localparam int unsigned PMAX = 2500;
`ifdef SERVO_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss_n = 1'b1;
  logic        miso, cs, frame_err;
  logic [1:0]  addr;
  logic [15:0] data;

  spi_servo_bridge #(.PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .cs(cs), .addr(addr), .data(data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cs_cnt = 0;
  int err_cnt = 0;

  // Frame-level reference state: last written register and shadow contents.
  logic [1:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_shadow [4] = '{default: 16'h0};

  // Count every clk in which a strobe is high; a stuck or stretched pulse shows up as >1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cs === 1'b1)        cs_cnt++;
      if (frame_err === 1'b1) err_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] clampv(input logic [15:0] v);
    int unsigned x;
    x = v;
    if (x < PMIN) x = PMIN;
    if (x > PMAX) x = PMAX;
    return 16'(x);
  endfunction

  task automatic half();
    repeat (5) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: set mosi with sclk low, sample miso just before the rise.
  task automatic drive_bit(input logic b, input bit raise_ss, output logic m);
    mosi = b;
    half();
    m = miso;
    sclk = 1'b1;
    if (raise_ss) ss_n = 1'b1;
    half();
    sclk = 1'b0;
  endtask

  task automatic send(input logic [23:0] f, input int nbits, input int extra, input bit simul,
                      output logic [15:0] rx);
    logic m;
    rx = '0;
    ss_n = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      drive_bit(f[23-i], simul && (i == nbits - 1), m);
      if (i >= 8 && i < 24) rx = {rx[14:0], m};
    end
    for (int i = 0; i < extra; i++) drive_bit(1'b1, 1'b0, m);
    half();
    ss_n = 1'b1;
    repeat (3) half();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [15:0] val,
                           input int nbits, input int extra, input bit simul);
    int cs0, er0, exp_cs, exp_er;
    logic [15:0] rx, exp_rx;
    exp_cs = 0;
    exp_er = 0;
    exp_rx = '0;
    if (nbits < 24) exp_er = 1;
    else if (cmd[6:2] != 5'd0) exp_er = 1;
    else if (cmd[7]) begin
      exp_cs = 1;
      m_addr = cmd[1:0];
      m_data = clampv(val);
      m_shadow[cmd[1:0]] = m_data;
    end else begin
      exp_rx = RB_EN ? m_shadow[cmd[1:0]] : 16'h0;
    end
    cs0 = cs_cnt;
    er0 = err_cnt;
    send({cmd, val}, nbits, extra, simul, rx);
    check({tag, " cs_pulses"}, 32'(cs_cnt - cs0), 32'(exp_cs));
    check({tag, " err_pulses"}, 32'(err_cnt - er0), 32'(exp_er));
    check({tag, " addr"}, 32'(addr), 32'(m_addr));
    check({tag, " data"}, 32'(data), 32'(m_data));
    if (nbits >= 24) check({tag, " miso_word"}, 32'(rx), 32'(exp_rx));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cs"}, 32'(cs), 32'd0);
    check({tag, " frame_err"}, 32'(frame_err), 32'd0);
    check({tag, " addr"}, 32'(addr), 32'd0);
    check({tag, " data"}, 32'(data), 32'd0);
    check({tag, " miso"}, 32'(miso), 32'd0);
  endtask

  initial begin
    logic m;
    int cs0, er0;
    logic [7:0] cmd;
    logic [15:0] val;
    int nb, ex;
    bit sim;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (4) half();

    run_frame("wr_a1_1500", 8'h81, 16'h05DC, 24, 0, 1'b0);
    run_frame("wr_clamp_lo", 8'h83, 16'h0064, 24, 0, 1'b0);
    run_frame("wr_clamp_hi", 8'h80, 16'hFFFF, 24, 0, 1'b0);
    run_frame("wr_at_min", 8'h82, 16'(PMIN), 24, 0, 1'b0);
    run_frame("wr_at_max", 8'h81, 16'(PMAX), 24, 0, 1'b0);
    run_frame("abort_13", 8'h81, 16'h0700, 13, 0, 1'b0);
    run_frame("resv_bit2", 8'h84, 16'h07D0, 24, 30, 1'b0);
    run_frame("simul_edge", 8'h83, 16'h0600, 24, 0, 1'b1);

    // Reset in the middle of a frame, then a clean frame.
    cs0 = cs_cnt;
    er0 = err_cnt;
    ss_n = 1'b0;
    half();
    for (int i = 0; i < 10; i++) drive_bit(i[0], 1'b0, m);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    ss_n = 1'b1;
    repeat (2) half();
    rst_n = 1'b1;
    m_addr = '0;
    m_data = '0;
    for (int i = 0; i < 4; i++) m_shadow[i] = '0;
    repeat (3) half();
    check("mid_rst cs_pulses", 32'(cs_cnt - cs0), 32'd0);
    check("mid_rst err_pulses", 32'(err_cnt - er0), 32'd0);
    run_frame("post_rst_wr", 8'h82, 16'h03E8, 24, 0, 1'b0);

    // Readback (miso checks degenerate to zero when readback is not built in).
    run_frame("rb_wr", 8'h82, 16'h0640, 24, 0, 1'b0);
    run_frame("rb_rd", 8'h02, 16'h0000, 24, 0, 1'b0);
    run_frame("rb_rd_empty", 8'h03, 16'hABCD, 24, 0, 1'b0);
    run_frame("rb_rd_resv", 8'h22, 16'h0000, 24, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      cmd[7]   = 1'($urandom_range(0, 1));
      cmd[6:2] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      cmd[1:0] = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       val = 16'($urandom_range(0, 600));
        1:       val = 16'($urandom_range(2400, 65535));
        default: val = 16'($urandom);
      endcase
      nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 23)) : 24;
      sim = (nb == 24) && ($urandom_range(0, 4) == 0);
      ex  = sim ? 0 : int'($urandom_range(0, 2));
      run_frame($sformatf("rnd%0d", k), cmd, val, nb, ex, sim);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_servo_bridge.md
Name: spi_servo_bridge

Overview:
SPI slave front end that receives servo position commands from an external host and writes them into the ServoController register interface (cs/addr/data).
- Sits directly upstream of the ServoController instance and replaces the hard-coded init sequencer.
- Oversamples the SPI pins on the system clock.
- Decodes fixed 24-bit frames and issues one single-cycle register write per valid frame.

Parameters:
PULSE_MIN, 500, lower clamp bound for written pulse width (unsigned, same units as ServoController data)
PULSE_MAX, 2500, upper clamp bound; PULSE_MIN <= PULSE_MAX required
SYNC_STAGES, 2, flip-flop depth of input synchronizers on sclk, mosi and ss_n (>= 2)

Ports:
clk  input  1  system clock; must be >= 8x sclk frequency
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
mosi  input  1  SPI data in, MSB first
ss_n  input  1  SPI slave select, active-low
miso  output  1  SPI data out (see Optional Feature)
cs  output  1  ServoController write strobe, one clk pulse per accepted write
addr  output  2  ServoController channel select
data  output  16  ServoController pulse-width value
frame_err  output  1  one-cycle pulse on a malformed or aborted frame

Behaviour:
- Reset (rst_n low, async): cs=0, addr=0, data=0, frame_err=0, miso=0, bit counter=0, shift register=0, state=IDLE. All synchronizer flops also clear; synchronizer reset value is sclk=0, ss_n=1.
- Synchronizers: sclk, mosi and ss_n each pass through SYNC_STAGES flops. Edges are detected on the synchronized signals against a one-flop delayed copy.
- Frame format, MSB first, 24 bits:
  - cmd[7:0]: bit7 = W (1 = write, 0 = read); bits6:2 reserved, must be 0; bits1:0 = addr.
  - val[15:0]: pulse width.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on synced ss_n falling edge; bit counter cleared.
  - SHIFT: on each synced sclk rising edge, shift in synced mosi and increment the counter. When the counter reaches 24, go to DONE.
  - SHIFT -> IDLE on synced ss_n rising edge with counter < 24: frame_err=1 for one cycle, no write.
  - DONE: further sclk edges are ignored. DONE -> IDLE on synced ss_n rising edge, with no error pulse.
- Write issue (cycle after the 24th edge is detected):
  - Reserved bits nonzero: frame_err=1 for one cycle; cs stays 0.
  - W=1 and reserved bits = 0: cs=1 for exactly one clk; addr=cmd[1:0]; data=clamp(val).
  - W=0: no cs pulse; read handling only.
- Clamp: unsigned 16-bit compare. val < PULSE_MIN gives PULSE_MIN; val > PULSE_MAX gives PULSE_MAX; otherwise val unchanged.
- Latency: cs asserts 1 clk after the clk in which the 24th synced rising edge is seen. Total latency from the pin edge is SYNC_STAGES+2 clk.
- addr and data hold their last written value after cs drops. data is never driven from a partial frame.
- Simultaneous events: if the 24th sclk rising edge and the ss_n rising edge are detected in the same clk, the sclk edge is processed first. The frame completes and the write is issued.
- ss_n falling edge while in SHIFT or DONE (glitch) is impossible without a preceding rise; the FSM ignores it.
- Reset mid-frame: frame discarded, no cs or frame_err. After reset, a new frame requires an ss_n high-to-low transition.
- Back-to-back frames: ss_n high for a minimum of SYNC_STAGES+2 clk between frames.

Optional Feature:
SERVO_READBACK_EN
- Defined:
  - Four 16-bit shadow registers, reset to 0. Each successful write updates shadow[addr] with the clamped value.
  - Read frame (W=0, reserved bits = 0): during bits 8..23, miso shifts out shadow[cmd[1:0]] MSB first.
  - Each bit is updated on the synced sclk falling edge following bit N-1. The MSB is presented after the falling edge that follows the 8th rising edge.
  - miso=0 at all other times.
- Undefined: no shadow storage; miso is tied 0.

Test Plan:
- Write frame 0x81, 0x05DC (addr 1, 1500) -> one cs pulse, addr=1, data=1500, frame_err=0.
- Write 0x83, 0x0064 (100) -> data=500 clamped; then 0x80, 0xFFFF -> data=2500 clamped.
- ss_n raised after 13 bits -> frame_err single pulse, no cs, addr/data unchanged.
- Frame 0x84 (reserved bit2 set), 0x07D0 -> frame_err pulse, no cs; 30 extra sclk edges after bit 24 ignored.
- rst_n low after bit 10, release, full write 0x82, 0x03E8 -> only one cs pulse, addr=2, data=1000.
- SERVO_READBACK_EN: write 0x82, 0x0640 (1600), then read 0x02, 0x0000 -> miso bits 8..23 = 0x0640, no cs on the read frame.
